// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection controller: phase encodings, request
// channel indices and the phase-to-channel serve map.
package traffic_pkg;

    typedef enum logic [1:0] {
        PH_SS_STRAIGHT = 2'd0,
        PH_SS_TURN     = 2'd1,
        PH_XS_STRAIGHT = 2'd2,
        PH_XS_TURN     = 2'd3
    } phase_e;

    localparam int NUM_CH    = 6;
    localparam int NUM_PHASE = 4;

    localparam int CH_SS_PED      = 0;
    localparam int CH_XS_PED      = 1;
    localparam int CH_SS_STRAIGHT = 2;
    localparam int CH_SS_TURN     = 3;
    localparam int CH_XS_STRAIGHT = 4;
    localparam int CH_XS_TURN     = 5;

    typedef logic [NUM_CH-1:0] ch_mask_t;

    localparam ch_mask_t MASK_PH0 = ch_mask_t'((1 << CH_SS_PED) | (1 << CH_SS_STRAIGHT));
    localparam ch_mask_t MASK_PH1 = ch_mask_t'(1 << CH_SS_TURN);
    localparam ch_mask_t MASK_PH2 = ch_mask_t'((1 << CH_XS_PED) | (1 << CH_XS_STRAIGHT));
    localparam ch_mask_t MASK_PH3 = ch_mask_t'(1 << CH_XS_TURN);

    // Indexed by phase encoding; the phase FSM uses the same table.
    localparam ch_mask_t [NUM_PHASE-1:0] SERVE_MASK = {MASK_PH3, MASK_PH2, MASK_PH1, MASK_PH0};

    function automatic ch_mask_t served_by(input phase_e ph);
        return SERVE_MASK[ph];
    endfunction

endpackage

// File: rtl/req_debounce.sv
// One request channel: 2-flop synchronizer then a saturating run-length counter.
// det rises DEBOUNCE_CYCLES+2 edges after the raw input first goes high; no backpressure.
// Any low synchronized sample restarts the count.
module req_debounce
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_in,
    output logic det
);

    localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = raw_in;
        sync2_d = sync1_q;
        cnt_d   = cnt_q;
        if (!sync2_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
        end
    end

    assign det = (cnt_q == CNT_MAX);

endmodule

// File: rtl/traffic_request_latch.sv
// Conditions six field requests into pending calls and reports the next phase with a call.
// pending follows det by one edge; call_valid/call_phase are combinational from pending and phase.
// No backpressure; optional per-channel wait timers under TRAFFIC_REQ_WAIT_TIMER_EN.
module traffic_request_latch
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int WAIT_W          = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] raw_req,
    input  logic [1:0]        phase,
    input  logic              phase_start,
    input  logic              sec_tick,
    output logic [NUM_CH-1:0] pending,
    output logic              call_valid,
`ifdef TRAFFIC_REQ_WAIT_TIMER_EN
    output logic [WAIT_W-1:0] max_wait,
`endif
    output logic [1:0]        call_phase
);

    phase_e   cur_phase;
    ch_mask_t cur_mask;
    ch_mask_t det;
    ch_mask_t pending_q, pending_d;

    assign cur_phase = phase_e'(phase);
    assign cur_mask  = served_by(cur_phase);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        req_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .rst_n  (rst_n),
            .raw_in (raw_req[g]),
            .det    (det[g])
        );
    end

    // Clear on the new phase's start takes priority over a same-cycle set.
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (phase_start && cur_mask[i]) begin
                pending_d[i] = 1'b0;
            end else if (det[i] && !cur_mask[i]) begin
                pending_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

    // Walk forward from the current phase; the current phase itself is never a candidate.
    logic       found;
    logic [1:0] cand;
    logic [1:0] call_phase_c;

    always_comb begin
        found        = 1'b0;
        cand         = phase;
        call_phase_c = 2'd0;
        for (int k = 1; k < NUM_PHASE; k++) begin
            cand = phase + 2'(k);
            if (!found && |(pending_q & SERVE_MASK[cand])) begin
                found        = 1'b1;
                call_phase_c = cand;
            end
        end
    end

    assign call_valid = |(pending_q & ~cur_mask);
    assign call_phase = call_phase_c;

`ifdef TRAFFIC_REQ_WAIT_TIMER_EN
    logic [WAIT_W-1:0] wait_q [NUM_CH];
    logic [WAIT_W-1:0] wait_d [NUM_CH];
    logic [WAIT_W-1:0] max_wait_q, max_wait_d;

    // Keyed off pending_d so a counter zeroes on the same edge its call clears.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            wait_d[i] = wait_q[i];
            if (!pending_d[i]) begin
                wait_d[i] = '0;
            end else if (sec_tick && pending_q[i] && (wait_q[i] != {WAIT_W{1'b1}})) begin
                wait_d[i] = wait_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        max_wait_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (wait_q[i] > max_wait_d) begin
                max_wait_d = wait_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wait_q[i] <= '0;
            end
            max_wait_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                wait_q[i] <= wait_d[i];
            end
            max_wait_q <= max_wait_d;
        end
    end

    assign max_wait = max_wait_q;
`else
    logic [WAIT_W-1:0] unused_tick;
    assign unused_tick = {WAIT_W{sec_tick}};
`endif

endmodule

// File: tb/tb_traffic_request_latch.sv
// Directed bench for traffic_request_latch with DEBOUNCE_CYCLES=20, WAIT_W=8.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_traffic_request_latch;

    logic       clk;
    logic       rst_n;
    logic [5:0] raw_req;
    logic [1:0] phase;
    logic       phase_start;
    logic       sec_tick;
    logic [5:0] pending;
    logic       call_valid;
    logic [1:0] call_phase;
`ifdef TRAFFIC_REQ_WAIT_TIMER_EN
    logic [7:0] max_wait;
`endif

    int vectors = 0;
    int errors  = 0;

    traffic_request_latch #(
        .DEBOUNCE_CYCLES(20),
        .WAIT_W(8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .raw_req     (raw_req),
        .phase       (phase),
        .phase_start (phase_start),
        .sec_tick    (sec_tick),
        .pending     (pending),
        .call_valid  (call_valid),
`ifdef TRAFFIC_REQ_WAIT_TIMER_EN
        .max_wait    (max_wait),
`endif
        .call_phase  (call_phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input logic [1:0] p);
        phase       = p;
        phase_start = 1'b1;
        tick(1);
        phase_start = 1'b0;
    endtask

    task automatic test_reset;
        #3;
        vectors++;
        if (pending !== 6'b0) begin
            errors++;
            $display("FAIL reset_pending got=%b want=%b", pending, 6'b0);
        end
        vectors++;
        if (call_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_call_valid got=%b want=0", call_valid);
        end
        vectors++;
        if (call_phase !== 2'd0) begin
            errors++;
            $display("FAIL reset_call_phase got=%0d want=0", call_phase);
        end
`ifdef TRAFFIC_REQ_WAIT_TIMER_EN
        vectors++;
        if (max_wait !== 8'd0) begin
            errors++;
            $display("FAIL reset_max_wait got=%0d want=0", max_wait);
        end
`endif
        #19 rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_latency;
        phase   = 2'd2;
        raw_req = 6'b000100;
        tick(22);
        vectors++;
        if (pending !== 6'b000000) begin
            errors++;
            $display("FAIL latency_edge22 got=%b want=%b", pending, 6'b000000);
        end
        tick(1);
        vectors++;
        if (pending !== 6'b000100) begin
            errors++;
            $display("FAIL latency_edge23 got=%b want=%b", pending, 6'b000100);
        end
        vectors++;
        if (call_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency_call_valid got=%b want=1", call_valid);
        end
        vectors++;
        if (call_phase !== 2'd0) begin
            errors++;
            $display("FAIL latency_call_phase got=%0d want=0", call_phase);
        end
        raw_req = 6'b0;
        tick(4);
        pulse_start(2'd0);
        vectors++;
        if (pending !== 6'b0) begin
            errors++;
            $display("FAIL latency_cleanup got=%b want=%b", pending, 6'b0);
        end
    endtask

    task automatic test_glitch;
        // Served-phase pulse, then unserved 19-cycle pulse, then 15-low-15 split pulse.
        phase   = 2'd0;
        raw_req = 6'b000001;
        tick(15);
        raw_req = 6'b0;
        tick(10);
        vectors++;
        if (pending !== 6'b0 || call_valid !== 1'b0) begin
            errors++;
            $display("FAIL glitch_15_ph0 got=%b/%b want=000000/0", pending, call_valid);
        end
        phase   = 2'd1;
        raw_req = 6'b000001;
        tick(19);
        raw_req = 6'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            vectors++;
            if (pending !== 6'b0 || call_valid !== 1'b0) begin
                errors++;
                $display("FAIL glitch_19 cyc=%0d got=%b/%b want=000000/0", i, pending, call_valid);
            end
        end
        raw_req = 6'b000001;
        tick(15);
        raw_req = 6'b0;
        tick(1);
        raw_req = 6'b000001;
        tick(15);
        raw_req = 6'b0;
        tick(8);
        vectors++;
        if (pending !== 6'b0) begin
            errors++;
            $display("FAIL glitch_split got=%b want=%b", pending, 6'b0);
        end
    endtask

    task automatic test_call_phase;
        phase   = 2'd0;
        raw_req = 6'b101000;
        tick(23);
        raw_req = 6'b0;
        tick(4);
        vectors++;
        if (pending !== 6'b101000) begin
            errors++;
            $display("FAIL callph_setup got=%b want=%b", pending, 6'b101000);
        end
        phase = 2'd1;
        #1;
        vectors++;
        if (call_phase !== 2'd3 || call_valid !== 1'b1) begin
            errors++;
            $display("FAIL callph_ph1 got=%0d/%b want=3/1", call_phase, call_valid);
        end
        tick(1);
        pulse_start(2'd3);
        vectors++;
        if (pending !== 6'b001000) begin
            errors++;
            $display("FAIL callph_clear5 got=%b want=%b", pending, 6'b001000);
        end
        vectors++;
        if (call_phase !== 2'd1 || call_valid !== 1'b1) begin
            errors++;
            $display("FAIL callph_ph3 got=%0d/%b want=1/1", call_phase, call_valid);
        end
        pulse_start(2'd1);
        vectors++;
        if (pending !== 6'b0 || call_valid !== 1'b0 || call_phase !== 2'd0) begin
            errors++;
            $display("FAIL callph_clear3 got=%b/%b/%0d want=000000/0/0", pending, call_valid, call_phase);
        end
    endtask

    task automatic test_held_in_served;
        phase   = 2'd0;
        raw_req = 6'b000100;
        for (int i = 0; i < 4; i++) begin
            tick(25);
            vectors++;
            if (pending !== 6'b0 || call_valid !== 1'b0) begin
                errors++;
                $display("FAIL held_blocked at=%0d got=%b/%b want=000000/0", (i + 1) * 25, pending, call_valid);
            end
        end
        pulse_start(2'd1);
        vectors++;
        if (pending !== 6'b000100) begin
            errors++;
            $display("FAIL held_rearm got=%b want=%b", pending, 6'b000100);
        end
        vectors++;
        if (call_phase !== 2'd0 || call_valid !== 1'b1) begin
            errors++;
            $display("FAIL held_call got=%0d/%b want=0/1", call_phase, call_valid);
        end
        raw_req = 6'b0;
        tick(4);
        pulse_start(2'd0);
        vectors++;
        if (pending !== 6'b0) begin
            errors++;
            $display("FAIL held_cleanup got=%b want=%b", pending, 6'b0);
        end
    endtask

    task automatic test_clear_wins;
        phase   = 2'd1;
        raw_req = 6'b010000;
        tick(22);
        vectors++;
        if (pending !== 6'b0) begin
            errors++;
            $display("FAIL clrwin_pre got=%b want=%b", pending, 6'b0);
        end
        pulse_start(2'd2);
        vectors++;
        if (pending !== 6'b0) begin
            errors++;
            $display("FAIL clrwin_same_cycle got=%b want=%b", pending, 6'b0);
        end
        tick(1);
        vectors++;
        if (pending !== 6'b0) begin
            errors++;
            $display("FAIL clrwin_served got=%b want=%b", pending, 6'b0);
        end
        // Phase value change with no start pulse: set-blocking follows, nothing clears.
        phase = 2'd3;
        tick(1);
        vectors++;
        if (pending !== 6'b010000) begin
            errors++;
            $display("FAIL clrwin_rearm got=%b want=%b", pending, 6'b010000);
        end
        vectors++;
        if (call_phase !== 2'd2 || call_valid !== 1'b1) begin
            errors++;
            $display("FAIL clrwin_call got=%0d/%b want=2/1", call_phase, call_valid);
        end
        phase = 2'd2;
        tick(1);
        vectors++;
        if (pending !== 6'b010000) begin
            errors++;
            $display("FAIL nostart_keep got=%b want=%b", pending, 6'b010000);
        end
        vectors++;
        if (call_valid !== 1'b0 || call_phase !== 2'd0) begin
            errors++;
            $display("FAIL nostart_call got=%b/%0d want=0/0", call_valid, call_phase);
        end
        raw_req = 6'b0;
        tick(4);
        pulse_start(2'd2);
        vectors++;
        if (pending !== 6'b0) begin
            errors++;
            $display("FAIL clrwin_cleanup got=%b want=%b", pending, 6'b0);
        end
    endtask

    task automatic test_reset_midway;
        phase   = 2'd0;
        raw_req = 6'b111111;
        tick(10);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick(22);
        vectors++;
        if (pending !== 6'b0) begin
            errors++;
            $display("FAIL rst_debounce_edge22 got=%b want=%b", pending, 6'b0);
        end
        tick(1);
        vectors++;
        if (pending !== 6'b111010) begin
            errors++;
            $display("FAIL multi_pending got=%b want=%b", pending, 6'b111010);
        end
        vectors++;
        if (call_phase !== 2'd1 || call_valid !== 1'b1) begin
            errors++;
            $display("FAIL multi_call got=%0d/%b want=1/1", call_phase, call_valid);
        end
        raw_req = 6'b0;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (pending !== 6'b0 || call_valid !== 1'b0 || call_phase !== 2'd0) begin
            errors++;
            $display("FAIL rst_async got=%b/%b/%0d want=000000/0/0", pending, call_valid, call_phase);
        end
        #1 rst_n = 1'b1;
        tick(3);
    endtask

`ifdef TRAFFIC_REQ_WAIT_TIMER_EN
    task automatic test_wait_timer;
        phase   = 2'd0;
        raw_req = 6'b100000;
        tick(23);
        raw_req = 6'b0;
        vectors++;
        if (pending !== 6'b100000 || max_wait !== 8'd0) begin
            errors++;
            $display("FAIL wait_setup got=%b/%0d want=100000/0", pending, max_wait);
        end
        for (int i = 0; i < 300; i++) begin
            sec_tick = 1'b1;
            tick(1);
            sec_tick = 1'b0;
            tick(1);
            if (i == 4) begin
                vectors++;
                if (max_wait !== 8'd5) begin
                    errors++;
                    $display("FAIL wait_5 got=%0d want=5", max_wait);
                end
            end
        end
        vectors++;
        if (max_wait !== 8'd255) begin
            errors++;
            $display("FAIL wait_saturate got=%0d want=255", max_wait);
        end
        pulse_start(2'd3);
        vectors++;
        if (pending !== 6'b0 || max_wait !== 8'd255) begin
            errors++;
            $display("FAIL wait_clear_edge got=%b/%0d want=000000/255", pending, max_wait);
        end
        tick(1);
        vectors++;
        if (max_wait !== 8'd0) begin
            errors++;
            $display("FAIL wait_cleared got=%0d want=0", max_wait);
        end
    endtask
`endif

    initial begin
        rst_n       = 1'b0;
        raw_req     = 6'b0;
        phase       = 2'd0;
        phase_start = 1'b0;
        sec_tick    = 1'b0;
        test_reset;
        test_latency;
        test_glitch;
        test_call_phase;
        test_held_in_served;
        test_clear_wins;
        test_reset_midway;
`ifdef TRAFFIC_REQ_WAIT_TIMER_EN
        test_wait_timer;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/traffic_request_latch.md
Name: traffic_request_latch

Overview:
- Front end for the intersection controller: conditions the six raw request inputs (2 pedestrian buttons, 4 car sensors) and latches each as a pending call.
- Clears a call when the controller starts the phase that serves it.
- Tells the controller whether any other phase is waiting and which phase comes next in cyclic order.
- Sits between the field inputs and the phase FSM, on the same 1 kHz clock.

Parameters:
- DEBOUNCE_CYCLES, 20: number of consecutive high synchronized samples needed to accept a request (20 ms at 1 kHz).
- WAIT_W, 8: width of the wait-seconds counters. Used only with WAIT_TIMER_EN.

Ports:
- clk  in  1  system clock, 1 kHz.
- rst_n  in  1  asynchronous active-low reset.
- raw_req  in  6  unsynchronized requests. Bit 0 straight-street pedestrian, 1 cross-street pedestrian, 2 straight-street straight-lane car, 3 straight-street turn-lane car, 4 cross-street straight-lane car, 5 cross-street turn-lane car.
- phase  in  2  current controller phase. 0 straight-street straight, 1 straight-street turn, 2 cross-street straight, 3 cross-street turn.
- phase_start  in  1  one-cycle pulse on the first cycle of a new phase; phase is already valid in that cycle.
- sec_tick  in  1  one-cycle pulse per second. Used only with WAIT_TIMER_EN.
- pending  out  6  latched calls, one bit per channel.
- call_valid  out  1  set when any pending channel is served by a phase other than the current one.
- call_phase  out  2  first phase after the current one, in cyclic order, that has a pending channel.
- max_wait  out  WAIT_W  largest wait counter over all channels. Present only with WAIT_TIMER_EN.

Behaviour:
- Reset is asynchronous and active-low. While rst_n is low: all synchronizers, debounce counters, pending, call_valid, call_phase and wait counters are 0.
- Serve map:
  - phase 0 serves channels 0 and 2.
  - phase 1 serves channel 3.
  - phase 2 serves channels 1 and 4.
  - phase 3 serves channel 5.
- Synchronizer: each raw_req bit passes through a 2-flop synchronizer, giving s[i].
- Debounce counter, per channel, width clog2(DEBOUNCE_CYCLES+1):
  - Clears to 0 whenever s[i]=0.
  - Otherwise increments and saturates at DEBOUNCE_CYCLES.
  - det[i] = (counter == DEBOUNCE_CYCLES).
- Latency: with raw_req[i] held high, pending[i] rises on the (DEBOUNCE_CYCLES+3)th rising edge after raw_req[i] is first sampled.
- Glitch rejection: any low sample before the counter saturates restarts the count. A pulse shorter than DEBOUNCE_CYCLES never sets pending.
- Set rule: pending[i] sets when det[i]=1 and channel i is not served by the current phase. A request held during its own served phase is ignored. Held car sensors and buttons re-arm after the phase ends.
- Clear rule: on phase_start, every channel served by the new phase clears.
- Simultaneous set and clear on the same channel in the same cycle: clear wins.
- Channels not served by the new phase keep their value or set normally.
- pending is level-held until cleared. Multiple channels may be pending at once.
- call_valid = OR of pending over channels not served by phase. Combinational from registered pending and phase.
- call_phase:
  - Searches phase+1, phase+2, phase+3 (mod 4) and returns the first with a pending channel.
  - Returns 0 when call_valid=0.
  - The current phase is never returned.
- A phase value change without phase_start clears nothing; only the served-set used for set-blocking and call_valid follows the new phase.
- Reset asserted mid-debounce or while pending discards all state immediately.

Optional Feature:
- Macro: TRAFFIC_REQ_WAIT_TIMER_EN.
- When defined:
  - Each channel has a WAIT_W-bit wait counter.
  - The counter clears when pending[i]=0 and increments on sec_tick while pending[i]=1, saturating at all-ones.
  - It clears in the same cycle pending clears.
  - max_wait is registered: max of all counters, one cycle late.
- When undefined: no counters, the max_wait port is absent, and sec_tick is ignored.

Decomposition:
- Shared package traffic_pkg holds:
  - Phase encodings 0–3.
  - Channel index constants 0–5.
  - The 4x6 serve-mask constant, also used by the phase FSM.
- Sub-module req_debounce: a single channel with synchronizer, debounce counter and det output, parameterized by DEBOUNCE_CYCLES and instantiated 6 times.
- Latch, call logic and wait counters stay in the top module.

Test Plan:
- Reset, phase=2, raw_req[2] held high from cycle 0 → pending=6'b000100 at edge 23 (DEBOUNCE_CYCLES=20), not at edge 22; call_valid=1; call_phase=0.
- phase=0, raw_req[0] pulses high for 15 cycles, then low → pending stays 0, call_valid stays 0.
- pending=6'b101000, phase=1 → call_phase=3. Then phase_start with phase=3 → pending=6'b001000, call_phase=1.
- phase=0, raw_req[2] held high for 100 cycles → pending[2] stays 0. Then phase_start with phase=1 → pending[2]=1 on the next edge.
- phase_start with phase=2 in the same cycle det[4] first asserts → pending[4]=0 (clear wins); pending[1] untouched if already 0.
- With TRAFFIC_REQ_WAIT_TIMER_EN, pending[5] held through 300 sec_tick pulses → max_wait=255. Then phase_start with phase=3 → max_wait=0 one cycle after the clear.
